// File: rtl/axis_pattern_src.sv
// AXI-Stream pattern source: emits a programmable-length frame of incrementing
// or LFSR data with optional idle gaps between beats, honouring back-pressure.
module axis_pattern_src #(
  parameter int                 DATA_W    = 4,
  parameter int                 LEN_W     = 8,
  parameter int                 GAP_W     = 4,
  parameter logic [DATA_W-1:0]  LFSR_TAPS = DATA_W'(4'b1100)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              mode_i,
  input  logic [DATA_W-1:0] seed_i,
  input  logic [GAP_W-1:0]  gap_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [LEN_W-1:0]  beat_cnt_o,
  output logic              tvalid_o,
  input  logic              tready_i,
  output logic [DATA_W-1:0] tdata_o,
  output logic              tlast_o
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t            state_reg, state_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic [LEN_W-1:0]  beat_cnt_reg, beat_cnt_next;
  logic              mode_reg, mode_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [GAP_W-1:0]  gap_reg, gap_next;
  logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;

  logic [DATA_W-1:0] tap_bits;
  logic [DATA_W-1:0] data_adv;
  logic              last_beat;
  logic              handshake;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_taps
      assign tap_bits[gi] = data_reg[gi] & LFSR_TAPS[gi];
    end
  endgenerate

  assign data_adv  = mode_reg ? {data_reg[DATA_W-2:0], ^tap_bits}
                              : data_reg + DATA_W'(1);
  assign last_beat = (beat_cnt_reg == len_reg - LEN_W'(1));

  // Outputs decode purely from registered state, so tvalid never sees tready.
  assign tvalid_o   = (state_reg == SEND);
  assign tlast_o    = tvalid_o & last_beat;
  assign tdata_o    = data_reg;
  assign busy_o     = (state_reg == SEND) || (state_reg == GAP);
  assign done_o     = (state_reg == DONE);
  assign beat_cnt_o = beat_cnt_reg;
  assign handshake  = tvalid_o & tready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      len_reg      <= '0;
      beat_cnt_reg <= '0;
      mode_reg     <= 1'b0;
      data_reg     <= '0;
      gap_reg      <= '0;
      gap_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      beat_cnt_reg <= beat_cnt_next;
      mode_reg     <= mode_next;
      data_reg     <= data_next;
      gap_reg      <= gap_next;
      gap_cnt_reg  <= gap_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    beat_cnt_next = beat_cnt_reg;
    mode_next     = mode_reg;
    data_next     = data_reg;
    gap_next      = gap_reg;
    gap_cnt_next  = gap_cnt_reg;

    unique case (state_reg)
      IDLE: begin
        if (start_i && (len_i != '0)) begin
          len_next      = len_i;
          mode_next     = mode_i;
          gap_next      = gap_i;
          beat_cnt_next = '0;
          // An all-zero LFSR state would lock up, so substitute all-ones.
          data_next     = (mode_i && (seed_i == '0)) ? '1 : seed_i;
          state_next    = SEND;
        end
      end
      SEND: begin
        if (handshake) begin
          beat_cnt_next = beat_cnt_reg + LEN_W'(1);
          data_next     = data_adv;
          if (last_beat) begin
            state_next = DONE;
          end else if (gap_reg != '0) begin
            gap_cnt_next = gap_reg;
            state_next   = GAP;
          end
        end
      end
      GAP: begin
        gap_cnt_next = gap_cnt_reg - GAP_W'(1);
        if (gap_cnt_reg == GAP_W'(1)) begin
          state_next = SEND;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
